// File: rtl/fb_mm_arbiter_if.sv
// Frame-buffer arbiter bus bundle: scanout host, draw host and the shared
// Avalon-MM agent port. The slave modport is the arbiter's view; the master
// modport is the view of the surrounding hosts plus agent.
interface fb_mm_arbiter_if #(
  parameter int unsigned ADDR_W = 20
);
  // Scanout host (read-only)
  logic [ADDR_W-1:0] scan_address;
  logic              scan_read;
  logic [15:0]       scan_readdata;
  logic              scan_waitrequest;
  // Draw host (read/write)
  logic [ADDR_W-1:0] draw_address;
  logic              draw_read;
  logic              draw_write;
  logic [15:0]       draw_writedata;
  logic [1:0]        draw_byteenable;
  logic [15:0]       draw_readdata;
  logic              draw_waitrequest;
  // Shared agent port
  logic [ADDR_W-1:0] mm_address;
  logic              mm_read;
  logic              mm_write;
  logic [15:0]       mm_writedata;
  logic [1:0]        mm_byteenable;
  logic [15:0]       mm_readdata;
  logic              mm_waitrequest;

  modport slave (
    input  scan_address, scan_read,
    output scan_readdata, scan_waitrequest,
    input  draw_address, draw_read, draw_write, draw_writedata, draw_byteenable,
    output draw_readdata, draw_waitrequest,
    output mm_address, mm_read, mm_write, mm_writedata, mm_byteenable,
    input  mm_readdata, mm_waitrequest
  );

  modport master (
    output scan_address, scan_read,
    input  scan_readdata, scan_waitrequest,
    output draw_address, draw_read, draw_write, draw_writedata, draw_byteenable,
    input  draw_readdata, draw_waitrequest,
    input  mm_address, mm_read, mm_write, mm_writedata, mm_byteenable,
    output mm_readdata, mm_waitrequest
  );
endinterface

// File: rtl/fb_mm_arbiter.sv
// Two-host arbiter for the 16-bit frame-buffer Avalon-MM agent port.
// Scanout has fixed priority; after MAX_SCAN_RUN consecutive scan grants with
// draw pending, draw is forced one grant. Every transfer costs one idle
// (arbitration) cycle plus the agent's wait cycles.
// Optional statistics counters: define FB_ARB_STATS_EN.
module fb_mm_arbiter #(
  parameter int unsigned MAX_SCAN_RUN = 8,
  parameter int unsigned ADDR_W       = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  fb_mm_arbiter_if.slave   bus
`ifdef FB_ARB_STATS_EN
  ,
  output logic [31:0]      scan_xfer_count,
  output logic [31:0]      draw_xfer_count,
  output logic [31:0]      draw_stall_cycles
`endif
);

  typedef enum logic [1:0] {
    GR_IDLE,
    GR_SCAN,
    GR_DRAW
  } gr_state_t;

  gr_state_t  state;
  logic [7:0] run_cnt;
  logic       draw_req;

  assign draw_req = bus.draw_read | bus.draw_write;

  // Grant FSM: arbitrate in idle, hold grant until completion or request drop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= GR_IDLE;
      run_cnt <= '0;
    end else begin
      case (state)
        GR_IDLE: begin
          if (bus.scan_read && !(draw_req && run_cnt == 8'(MAX_SCAN_RUN))) begin
            state   <= GR_SCAN;
            run_cnt <= draw_req ? run_cnt + 8'd1 : '0;
          end else if (draw_req) begin
            state   <= GR_DRAW;
            run_cnt <= '0;
          end
        end
        GR_SCAN: begin
          if (!bus.scan_read || !bus.mm_waitrequest) state <= GR_IDLE;
        end
        GR_DRAW: begin
          if (!draw_req || !bus.mm_waitrequest) state <= GR_IDLE;
        end
        default: state <= GR_IDLE;
      endcase
    end
  end

  // Route the granted host straight through to the agent port
  always_comb begin
    bus.scan_readdata    = bus.mm_readdata;
    bus.draw_readdata    = bus.mm_readdata;
    bus.scan_waitrequest = 1'b1;
    bus.draw_waitrequest = 1'b1;
    bus.mm_address       = {ADDR_W{1'b0}};
    bus.mm_read          = 1'b0;
    bus.mm_write         = 1'b0;
    bus.mm_writedata     = '0;
    bus.mm_byteenable    = '0;
    case (state)
      GR_SCAN: begin
        bus.mm_address       = bus.scan_address;
        bus.mm_read          = bus.scan_read;
        bus.mm_byteenable    = 2'b11;
        bus.scan_waitrequest = bus.mm_waitrequest;
      end
      GR_DRAW: begin
        bus.mm_address       = bus.draw_address;
        // read+write together is treated as a write
        bus.mm_read          = bus.draw_read & ~bus.draw_write;
        bus.mm_write         = bus.draw_write;
        bus.mm_writedata     = bus.draw_writedata;
        bus.mm_byteenable    = bus.draw_byteenable;
        bus.draw_waitrequest = bus.mm_waitrequest;
      end
      default: ;
    endcase
  end

`ifdef FB_ARB_STATS_EN
  // Transfer and draw-stall counters, free-running modulo 2^32
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_xfer_count   <= '0;
      draw_xfer_count   <= '0;
      draw_stall_cycles <= '0;
    end else begin
      if (state == GR_SCAN && bus.scan_read && !bus.mm_waitrequest)
        scan_xfer_count <= scan_xfer_count + 32'd1;
      if (state == GR_DRAW && draw_req && !bus.mm_waitrequest)
        draw_xfer_count <= draw_xfer_count + 32'd1;
      if (draw_req && bus.draw_waitrequest)
        draw_stall_cycles <= draw_stall_cycles + 32'd1;
    end
  end
`else
  // Statistics disabled: no counters, arbitration unchanged.
`endif

endmodule

// File: tb/tb_fb_mm_arbiter.sv
// Self-checking bench for fb_mm_arbiter: directed vectors, an owner-based
// behavioural model checked every cycle, and literal expectations.
module tb_fb_mm_arbiter;
  localparam int MAX = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  fb_mm_arbiter_if #(.ADDR_W(20)) bus ();

`ifdef FB_ARB_STATS_EN
  logic [31:0] scan_xfer_count, draw_xfer_count, draw_stall_cycles;
`endif

  fb_mm_arbiter #(.MAX_SCAN_RUN(MAX), .ADDR_W(20)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef FB_ARB_STATS_EN
    ,
    .scan_xfer_count   (scan_xfer_count),
    .draw_xfer_count   (draw_xfer_count),
    .draw_stall_cycles (draw_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Agent: zero-latency read data derived from the presented address
  assign bus.mm_readdata = bus.mm_address[15:0] ^ 16'h5A5A;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner: 0 nobody, 1 scanout, 2 draw. streak: scan grants in a row with draw waiting.
  int    owner = 0;
  int    streak = 0;
  int    m_scan_done = 0;
  int    m_draw_done = 0;
  int    m_stall = 0;
  string mlog = "";

  always @(negedge reset_n) begin
    owner = 0; streak = 0; m_scan_done = 0; m_draw_done = 0; m_stall = 0;
  end

  always @(negedge clk) begin
    logic [19:0] e_addr;
    logic        e_rd, e_wr, e_sw, e_dw, dreq;
    logic [15:0] e_wd;
    logic [1:0]  e_be;
    dreq = bus.draw_read | bus.draw_write;
    if (!reset_n) begin
      owner = 0; streak = 0; m_scan_done = 0; m_draw_done = 0; m_stall = 0;
    end
    e_addr = '0; e_rd = 0; e_wr = 0; e_wd = '0; e_be = '0; e_sw = 1; e_dw = 1;
    if (owner == 1) begin
      e_addr = bus.scan_address; e_rd = bus.scan_read; e_be = 2'b11;
      e_sw = bus.mm_waitrequest;
    end else if (owner == 2) begin
      e_addr = bus.draw_address; e_wr = bus.draw_write;
      e_rd = bus.draw_read && !bus.draw_write;
      e_wd = bus.draw_writedata; e_be = bus.draw_byteenable;
      e_dw = bus.mm_waitrequest;
    end
    check("mm_address", 32'(bus.mm_address), 32'(e_addr));
    check("mm_read", 32'(bus.mm_read), 32'(e_rd));
    check("mm_write", 32'(bus.mm_write), 32'(e_wr));
    check("mm_writedata", 32'(bus.mm_writedata), 32'(e_wd));
    check("mm_byteenable", 32'(bus.mm_byteenable), 32'(e_be));
    check("scan_waitrequest", 32'(bus.scan_waitrequest), 32'(e_sw));
    check("draw_waitrequest", 32'(bus.draw_waitrequest), 32'(e_dw));
    check("scan_readdata", 32'(bus.scan_readdata), 32'(e_addr[15:0] ^ 16'h5A5A));
    check("draw_readdata", 32'(bus.draw_readdata), 32'(e_addr[15:0] ^ 16'h5A5A));
    if (reset_n) begin
      if (dreq && e_dw) m_stall++;
      // advance to the owner after the coming rising edge
      if (owner == 0) begin
        if (bus.scan_read && !(dreq && streak == MAX)) begin
          owner = 1; streak = dreq ? streak + 1 : 0;
        end else if (dreq) begin
          owner = 2; streak = 0;
        end
      end else if (owner == 1) begin
        if (bus.scan_read && !bus.mm_waitrequest) begin m_scan_done++; mlog = {mlog, "S"}; end
        if (!bus.scan_read || !bus.mm_waitrequest) owner = 0;
      end else begin
        if (dreq && !bus.mm_waitrequest) begin m_draw_done++; mlog = {mlog, "D"}; end
        if (!dreq || !bus.mm_waitrequest) owner = 0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One scan transfer; scan_read is left asserted afterwards
  task automatic scan_xfer(input logic [19:0] a, output int ncyc, output int nrd);
    bit done = 0;
    bus.scan_address = a; bus.scan_read = 1'b1;
    ncyc = 0; nrd = 0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk); ncyc++;
      if (bus.mm_read) nrd++;
      if (!bus.scan_waitrequest) done = 1;
    end
    if (!done) check("scan_timeout", 32'd1, 32'd0);
    tick();
  endtask

  // One zero-wait draw transfer, request dropped afterwards
  task automatic draw_xfer(input logic [19:0] a, input bit wr);
    bit done = 0;
    bus.draw_address = a; bus.draw_write = wr; bus.draw_read = !wr;
    bus.draw_writedata = 16'h1234; bus.draw_byteenable = 2'b10;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (!bus.draw_waitrequest) done = 1;
    end
    if (!done) check("draw_timeout", 32'd1, 32'd0);
    tick();
    bus.draw_write = 0; bus.draw_read = 0;
  endtask

  task automatic idle_inputs();
    bus.scan_address = '0; bus.scan_read = 0;
    bus.draw_address = '0; bus.draw_read = 0; bus.draw_write = 0;
    bus.draw_writedata = '0; bus.draw_byteenable = '0;
    bus.mm_waitrequest = 0;
  endtask

  initial begin
    int    c, r, csum, rsum, n, wcnt;
    string glog, exp_seq;
    bit    ok;
    idle_inputs();
    reset_n = 0;
    repeat (2) @(negedge clk);
    // reset state
    check("rst_mm_read", 32'(bus.mm_read), 32'd0);
    check("rst_mm_write", 32'(bus.mm_write), 32'd0);
    check("rst_scan_wait", 32'(bus.scan_waitrequest), 32'd1);
    check("rst_draw_wait", 32'(bus.draw_waitrequest), 32'd1);
    check("rst_mm_address", 32'(bus.mm_address), 32'd0);
    @(posedge clk); #2 reset_n = 1;
    tick();

    // T1: scan only, addresses 0..3
    csum = 0; rsum = 0;
    for (int i = 0; i < 4; i++) begin
      scan_xfer(20'(i), c, r);
      csum += c; rsum += r;
    end
    bus.scan_read = 0;
    check("t1_cycles", 32'(csum), 32'd8);
    check("t1_mm_read_pulses", 32'(rsum), 32'd4);
    check("t1_model_scans", 32'(m_scan_done), 32'd4);
    tick();

    // T2: both hosts requesting continuously, 27 grants
    mlog = ""; glog = ""; n = 0;
    exp_seq = "";
    for (int p = 0; p < 3; p++) exp_seq = {exp_seq, "SSSSSSSSD"};
    bus.scan_address = 20'h00100; bus.scan_read = 1;
    bus.draw_address = 20'h00200; bus.draw_write = 1;
    bus.draw_writedata = 16'h0F0F; bus.draw_byteenable = 2'b11;
    for (int k = 0; k < 300 && n < 27; k++) begin
      @(negedge clk);
      if (!bus.scan_waitrequest) begin glog = {glog, "S"}; n++; end
      if (!bus.draw_waitrequest) begin glog = {glog, "D"}; n++; end
    end
    if (n < 27) check("t2_timeout", 32'(n), 32'd27);
    tick();
    bus.scan_read = 0; bus.draw_write = 0;
    check("t2_dut_grant_seq", 32'(glog == exp_seq), 32'd1);
    check("t2_model_grant_seq", 32'(mlog == exp_seq), 32'd1);
    tick();

    // T3: draw write with 3 agent wait cycles
    bus.mm_waitrequest = 1;
    bus.draw_address = 20'hABC01; bus.draw_write = 1;
    bus.draw_writedata = 16'hABCD; bus.draw_byteenable = 2'b01;
    wcnt = 0; ok = 1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.mm_write) begin
        wcnt++;
        if (bus.mm_address !== 20'hABC01 || bus.mm_writedata !== 16'hABCD ||
            bus.mm_byteenable !== 2'b01 || bus.scan_waitrequest !== 1'b1) ok = 0;
      end
      if (!bus.draw_waitrequest) break;
      tick();
      if (wcnt == 3) bus.mm_waitrequest = 0;
    end
    check("t3_write_cycles", 32'(wcnt), 32'd4);
    check("t3_stable", 32'(ok), 32'd1);
    tick();
    bus.draw_write = 0;
    tick();

    // T4: read and write together -> write
    bus.draw_read = 1; bus.draw_write = 1; bus.draw_address = 20'h00042;
    @(negedge clk); @(negedge clk);
    check("t4_mm_write", 32'(bus.mm_write), 32'd1);
    check("t4_mm_read", 32'(bus.mm_read), 32'd0);
    tick();
    bus.draw_read = 0; bus.draw_write = 0;
    tick();

    // T5: asynchronous reset in the middle of a draw transfer
    bus.mm_waitrequest = 1; bus.draw_write = 1; bus.draw_address = 20'h00077;
    ok = 0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      if (bus.mm_write) ok = 1;
    end
    check("t5_in_draw", 32'(ok), 32'd1);
    #2 reset_n = 0;
    #1;
    check("t5_async_mm_write", 32'(bus.mm_write), 32'd0);
    check("t5_async_draw_wait", 32'(bus.draw_waitrequest), 32'd1);
    check("t5_async_scan_wait", 32'(bus.scan_waitrequest), 32'd1);
    bus.mm_waitrequest = 0; bus.scan_read = 1; bus.scan_address = 20'h00055;
    @(posedge clk); #2 reset_n = 1;
    glog = "";
    for (int k = 0; k < 20 && glog.len() == 0; k++) begin
      @(negedge clk);
      if (!bus.scan_waitrequest) glog = "S";
      else if (!bus.draw_waitrequest) glog = "D";
    end
    check("t5_first_grant_scan", 32'(glog == "S"), 32'd1);
    tick();
    bus.scan_read = 0; bus.draw_write = 0;
    tick();

    // T6: 10 scan + 2 draw transfers from a fresh reset
    #2 reset_n = 0;
    tick();
    @(posedge clk); #2 reset_n = 1;
    tick();
    for (int i = 0; i < 10; i++) scan_xfer(20'(16 + i), c, r);
    bus.scan_read = 0;
    draw_xfer(20'h00300, 1);
    draw_xfer(20'h00301, 0);
    tick();
    check("t6_model_scans", 32'(m_scan_done), 32'd10);
    check("t6_model_draws", 32'(m_draw_done), 32'd2);
    check("t6_model_stalls", 32'(m_stall), 32'd2);
`ifdef FB_ARB_STATS_EN
    check("t6_scan_xfer_count", scan_xfer_count, 32'd10);
    check("t6_draw_xfer_count", draw_xfer_count, 32'd2);
    check("t6_draw_stall_cycles", draw_stall_cycles, 32'(m_stall));
`endif
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
